// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and widths for the multiply-accumulate datapath
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 48;
  localparam int CNT_W_DEF = 16;
  localparam int PROD_W    = 32;

endpackage

// File: rtl/mult_accum_add.sv
// rtl/mult_accum_add.sv - accumulator adder; saturating carry path when MULT_ACCUM_SAT_EN is defined
module mult_accum_add
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
`ifdef MULT_ACCUM_SAT_EN
  output logic              carry,
`endif
  output logic [ACC_W-1:0]  sum
);

`ifdef MULT_ACCUM_SAT_EN
  // One extra bit catches the carry-out; on carry the sum pins to all-ones,
  // and an all-ones accumulator plus any non-zero product carries again.
  logic [ACC_W:0] wide;

  assign wide  = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = wide[ACC_W];
  assign sum   = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  // Plain modulo-2^ACC_W add of the zero-extended product.
  assign sum = acc + ACC_W'(prod);
`endif

endmodule

// File: rtl/mult_accum.sv
// rtl/mult_accum.sv - product accumulator with last-marked result handshake; MULT_ACCUM_SAT_EN enables saturation
module mult_accum
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              ovf
);

  state_t              state;
  state_t              state_nxt;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    add_sum;
  logic [PROD_W-1:0]   prod_g;
  logic                accept;

  // Result is held in the accumulator itself, so HOLD blocks new input.
  assign out_valid = (state == HOLD);
  assign in_ready  = ~rst & ~out_valid;
  assign accept    = in_valid & in_ready;
  assign out_sum   = acc;
  assign out_cnt   = cnt;

  // Gate the product so an undriven bus between terms cannot reach the adder.
  assign prod_g = accept ? prod : '0;

`ifdef MULT_ACCUM_SAT_EN
  logic add_carry;
  logic ovf_q;

  mult_accum_add #(.ACC_W(ACC_W)) u_add (
    .acc   (acc),
    .prod  (prod_g),
    .carry (add_carry),
    .sum   (add_sum)
  );

  // Sticky saturation flag, presented with the result and cleared on handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) ovf_q <= 1'b0;
    end else if (accept && add_carry) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  mult_accum_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .prod (prod_g),
    .sum  (add_sum)
  );

  assign ovf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a last-marked accept closes the sum, a taken result reopens.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) state_nxt = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Running sum and saturating term count; both clear when the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end else if (accept) begin
      acc <= add_sum;
      if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// tb/tb_mult_accum.sv - scoreboard bench for mult_accum at ACC_W=48 and ACC_W=32
module tb_mult_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] prod = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_sum;
  logic [15:0] out_cnt;
  logic        ovf;

  logic        v32 = 1'b0;
  logic        rdy32;
  logic [31:0] p32 = '0;
  logic        l32 = 1'b0;
  logic        ov32;
  logic        ro32 = 1'b1;
  logic [31:0] sum32;
  logic [15:0] cnt32;
  logic        ovf32;

  typedef struct {
    logic [47:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mult_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .ovf       (ovf)
  );

  mult_accum #(.ACC_W(32), .CNT_W(16)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v32),
    .in_ready  (rdy32),
    .prod      (p32),
    .in_last   (l32),
    .out_valid (ov32),
    .out_ready (ro32),
    .out_sum   (sum32),
    .out_cnt   (cnt32),
    .ovf       (ovf32)
  );

  task automatic send(input logic [31:0] p, input logic l);
    in_valid = 1'b1;
    prod     = p;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    prod     = 32'hxxxx_xxxx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_sum !== 48'd0) begin n_bad++; $display("FAIL reset_out_sum got %0h want 0", out_sum); end
    n_cmp++; if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    q.push_back('{sum: 48'd60, cnt: 16'd3, ovf: 1'b0});
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_latency out_valid got %b want 1", out_valid); end
    e = q.pop_front();
    n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL b2b_sum got %0d want %0d", out_sum, e.sum); end
    n_cmp++; if (out_cnt !== e.cnt) begin n_bad++; $display("FAIL b2b_cnt got %0d want %0d", out_cnt, e.cnt); end
    n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL b2b_ovf got %b want %b", ovf, e.ovf); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_in_ready got %b want 0", in_ready); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL b2b_idle_cnt got %0d want 0", out_cnt); end
    n_cmp++; if (out_sum !== 48'd0) begin n_bad++; $display("FAIL b2b_idle_sum got %0d want 0", out_sum); end
  endtask

  task automatic test_single;
    q.push_back('{sum: 48'h0000_FFFF_FFFF, cnt: 16'd1, ovf: 1'b0});
    send(32'hFFFF_FFFF, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", out_valid); end
    e = q.pop_front();
    n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL single_sum got %0h want %0h", out_sum, e.sum); end
    n_cmp++; if (out_cnt !== e.cnt) begin n_bad++; $display("FAIL single_cnt got %0d want %0d", out_cnt, e.cnt); end
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    q.push_back('{sum: 48'd8, cnt: 16'd1, ovf: 1'b0});
    send(32'd8, 1'b1);
    e = q.pop_front();
    in_valid = 1'b1;
    prod     = 32'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL bp_sum[%0d] got %0d want %0d", i, out_sum, e.sum); end
      n_cmp++; if (out_cnt !== e.cnt) begin n_bad++; $display("FAIL bp_cnt[%0d] got %0d want %0d", i, out_cnt, e.cnt); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    q.push_back('{sum: 48'd99, cnt: 16'd1, ovf: 1'b0});
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_bubble_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_bubble_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    e = q.pop_front();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL bp_next_sum got %0d want %0d", out_sum, e.sum); end
    n_cmp++; if (out_cnt !== e.cnt) begin n_bad++; $display("FAIL bp_next_cnt got %0d want %0d", out_cnt, e.cnt); end
    idle(1);
  endtask

  task automatic test_gaps;
    q.push_back('{sum: 48'd12, cnt: 16'd2, ovf: 1'b0});
    send(32'd5, 1'b0);
    in_last = 1'b1;
    idle(3);
    in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_valid got %b want 0", out_valid); end
    send(32'd7, 1'b1);
    e = q.pop_front();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL gap_end_valid got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL gap_sum got %0d want %0d", out_sum, e.sum); end
    n_cmp++; if (out_cnt !== e.cnt) begin n_bad++; $display("FAIL gap_cnt got %0d want %0d", out_cnt, e.cnt); end
    idle(1);
  endtask

  task automatic test_overflow;
`ifdef MULT_ACCUM_SAT_EN
    q.push_back('{sum: 48'hFFFF_FFFF, cnt: 16'd2, ovf: 1'b1});
`else
    q.push_back('{sum: 48'd1, cnt: 16'd2, ovf: 1'b0});
`endif
    v32 = 1'b1; p32 = 32'hFFFF_FFFF; l32 = 1'b0;
    @(posedge clk); #1;
    p32 = 32'd2; l32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; l32 = 1'b0;
    e = q.pop_front();
    n_cmp++; if (ov32 !== 1'b1) begin n_bad++; $display("FAIL ovf32_valid got %b want 1", ov32); end
    n_cmp++; if ({16'd0, sum32} !== e.sum) begin n_bad++; $display("FAIL ovf32_sum got %0h want %0h", sum32, e.sum); end
    n_cmp++; if (cnt32 !== e.cnt) begin n_bad++; $display("FAIL ovf32_cnt got %0d want %0d", cnt32, e.cnt); end
    n_cmp++; if (ovf32 !== e.ovf) begin n_bad++; $display("FAIL ovf32_flag got %b want %b", ovf32, e.ovf); end
    @(posedge clk); #1;
    n_cmp++; if (ovf32 !== 1'b0) begin n_bad++; $display("FAIL ovf32_clear got %b want 0", ovf32); end
  endtask

  task automatic test_async_reset;
    send(32'd3, 1'b0);
    send(32'd6, 1'b0);
    n_cmp++; if (out_sum !== 48'd9) begin n_bad++; $display("FAIL ar_partial_sum got %0d want 9", out_sum); end
    n_cmp++; if (out_cnt !== 16'd2) begin n_bad++; $display("FAIL ar_partial_cnt got %0d want 2", out_cnt); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_sum !== 48'd0) begin n_bad++; $display("FAIL ar_sum got %0d want 0", out_sum); end
    n_cmp++; if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL ar_cnt got %0d want 0", out_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ar_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    q.push_back('{sum: 48'd4, cnt: 16'd1, ovf: 1'b0});
    send(32'd4, 1'b1);
    e = q.pop_front();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_after_valid got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL ar_after_sum got %0d want %0d", out_sum, e.sum); end
    n_cmp++; if (out_cnt !== e.cnt) begin n_bad++; $display("FAIL ar_after_cnt got %0d want %0d", out_cnt, e.cnt); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_backpressure();
    test_gaps();
    test_overflow();
    test_async_reset();
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
